// File: rtl/spi_flash_responder.sv
// spi_flash_responder
//   On-chip SPI mode-0 serial-flash target. It accepts WREN (06), WRDI (04),
//   RDSR (05), READ (03) and PAGE PROGRAM (02), and stores data in a
//   2^MEM_AW byte array that powers up as all 8'hFF.
//
// Ports
//   clk      system clock, at least 8x the SCK frequency
//   rst      asynchronous active-low reset
//   SCK      SPI clock from the controller (asynchronous to clk)
//   CSbar    active-low chip select (asynchronous to clk)
//   DI       serial data in, MSB first, sampled on SCK rise
//   DO       serial data out, MSB first, updated on SCK fall
//   busy     status bit 0, write in progress
//   wel      status bit 1, write enable latch
//   last_cmd opcode of the most recently completed command byte
//
// state    | meaning
// S_IDLE   | chip deselected, waiting for CSbar fall
// S_CMD    | shifting in the opcode byte
// S_ADDR   | shifting in the 24-bit address
// S_READ   | streaming array bytes out on DO
// S_PROG   | receiving bytes to program into the array
// S_STATUS | streaming {6'b0, wel, busy} out on DO
// S_IGNORE | opcode done or rejected, wait for CSbar rise
module spi_flash_responder #(
    parameter int MEM_AW      = 8,
    parameter int BUSY_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SCK,
    input  logic       CSbar,
    input  logic       DI,
    output logic       DO,
    output logic       busy,
    output logic       wel,
    output logic [7:0] last_cmd
);

    localparam int DEPTH = 1 << MEM_AW;
    localparam int BW    = $clog2(BUSY_CYCLES + 1);
    localparam logic [MEM_AW-1:0] PTR_ONE   = {{(MEM_AW-1){1'b0}}, 1'b1};
    localparam logic [BW-1:0]     BUSY_LOAD = BW'(BUSY_CYCLES);
    localparam logic [BW-1:0]     BUSY_ONE  = BW'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_READ, S_PROG, S_STATUS, S_IGNORE
    } state_t;

    state_t r_state, w_state_nxt;

    logic [1:0] r_sck_sync, r_cs_sync, r_di_sync;
    logic       r_sck_q, r_cs_q;
    logic       w_sck, w_cs, w_di;
    logic       w_sck_rise, w_sck_fall, w_cs_fall, w_cs_rise;

    logic [2:0]        r_bit_cnt;
    logic [6:0]        r_sh;
    logic [7:0]        w_byte;
    logic              w_byte_done;
    logic [1:0]        r_addr_cnt;
    logic              r_is_prog;
    logic              r_written;
    logic [MEM_AW-1:0] r_ptr, w_ptr_pinc;
    logic [2:0]        r_out_cnt;
    logic [6:0]        r_tx;
    logic [7:0]        w_src, w_cur;
    logic [BW-1:0]     r_busy_cnt;
    logic              w_set_wel, w_clr_wel, w_mem_we, w_commit, w_drive;

    // Array is deliberately outside reset so contents survive rst.
    logic [7:0] r_mem [DEPTH] = '{default: 8'hFF};

    assign w_sck      = r_sck_sync[1];
    assign w_cs       = r_cs_sync[1];
    assign w_di       = r_di_sync[1];
    assign w_sck_rise = w_sck & ~r_sck_q;
    assign w_sck_fall = ~w_sck & r_sck_q;
    assign w_cs_fall  = ~w_cs & r_cs_q;
    assign w_cs_rise  = w_cs & ~r_cs_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sck_sync <= 2'b00;
            r_cs_sync  <= 2'b11;
            r_di_sync  <= 2'b00;
            r_sck_q    <= 1'b0;
            r_cs_q     <= 1'b1;
        end else begin
            r_sck_sync <= {r_sck_sync[0], SCK};
            r_cs_sync  <= {r_cs_sync[0], CSbar};
            r_di_sync  <= {r_di_sync[0], DI};
            r_sck_q    <= w_sck;
            r_cs_q     <= w_cs;
        end
    end

    assign w_byte      = {r_sh, w_di};
    assign w_byte_done = w_sck_rise && (r_bit_cnt == 3'd7);

    // Program pointer wraps within the 256-byte page.
    generate
        if (MEM_AW > 8) begin : g_page_wrap
            assign w_ptr_pinc = {r_ptr[MEM_AW-1:8], r_ptr[7:0] + 8'd1};
        end else begin : g_flat_wrap
            assign w_ptr_pinc = r_ptr + PTR_ONE;
        end
    endgenerate

    assign w_drive  = (r_state == S_READ) || (r_state == S_STATUS);
    assign w_mem_we = w_byte_done && (r_state == S_PROG) && wel;
    // A byte finishing in the same clk as CSbar rise still counts.
    assign w_commit = w_cs_rise && (r_state == S_PROG) && (r_written || w_mem_we);
    // Source byte is captured only at the first fall of each byte.
    assign w_src    = (r_state == S_READ) ? r_mem[r_ptr] : {6'b0, wel, busy};
    assign w_cur    = (r_out_cnt == 3'd0) ? w_src : {r_tx, 1'b0};

    always_comb begin
        w_state_nxt = r_state;
        w_set_wel   = 1'b0;
        w_clr_wel   = 1'b0;
        case (r_state)
            S_IDLE: if (w_cs_fall) w_state_nxt = S_CMD;
            S_CMD: begin
                if (w_byte_done) begin
                    if (busy && (w_byte != 8'h05)) begin
                        w_state_nxt = S_IGNORE;
                    end else begin
                        case (w_byte)
                            8'h06: begin w_set_wel = 1'b1; w_state_nxt = S_IGNORE; end
                            8'h04: begin w_clr_wel = 1'b1; w_state_nxt = S_IGNORE; end
                            8'h05: w_state_nxt = S_STATUS;
                            8'h03, 8'h02: w_state_nxt = S_ADDR;
                            default: w_state_nxt = S_IGNORE;
                        endcase
                    end
                end
            end
            S_ADDR: begin
                if (w_byte_done && (r_addr_cnt == 2'd2))
                    w_state_nxt = r_is_prog ? S_PROG : S_READ;
            end
            default: ;
        endcase
        if (w_cs_rise && (r_state != S_IDLE)) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bit_cnt  <= 3'd0;
            r_sh       <= 7'd0;
            r_addr_cnt <= 2'd0;
            r_is_prog  <= 1'b0;
            r_written  <= 1'b0;
            r_ptr      <= '0;
            r_out_cnt  <= 3'd0;
            r_tx       <= 7'd0;
            r_busy_cnt <= '0;
            DO         <= 1'b0;
            busy       <= 1'b0;
            wel        <= 1'b0;
            last_cmd   <= 8'h00;
        end else begin
            if (w_cs_fall) begin
                r_bit_cnt <= 3'd0;
            end else if (w_sck_rise) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
                r_sh      <= w_byte[6:0];
            end

            if ((r_state == S_CMD) && w_byte_done) begin
                last_cmd   <= w_byte;
                r_is_prog  <= (w_byte == 8'h02);
                r_addr_cnt <= 2'd0;
                r_written  <= 1'b0;
            end

            if ((r_state == S_ADDR) && w_sck_rise) begin
                r_ptr <= {r_ptr[MEM_AW-2:0], w_di};
                if (w_byte_done) r_addr_cnt <= r_addr_cnt + 2'd1;
            end

            if ((r_state == S_PROG) && w_byte_done) begin
                r_ptr <= w_ptr_pinc;
                if (wel) r_written <= 1'b1;
            end

            if (!w_drive || w_cs) begin
                DO        <= 1'b0;
                r_out_cnt <= 3'd0;
            end else if (w_sck_fall) begin
                DO        <= w_cur[7];
                r_tx      <= w_cur[6:0];
                r_out_cnt <= r_out_cnt + 3'd1;
                if ((r_state == S_READ) && (r_out_cnt == 3'd7)) r_ptr <= r_ptr + PTR_ONE;
            end

            if (w_set_wel) wel <= 1'b1;
            if (w_clr_wel || w_commit) wel <= 1'b0;

            if (w_commit) begin
                busy       <= 1'b1;
                r_busy_cnt <= BUSY_LOAD;
            end else if (busy) begin
                r_busy_cnt <= r_busy_cnt - BUSY_ONE;
                if (r_busy_cnt == BUSY_ONE) busy <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[r_ptr] <= w_byte;
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// tb_spi_flash_responder
//   Drives SPI mode-0 transactions into spi_flash_responder and compares the
//   returned bytes and status outputs against a byte-level flash model.
module tb_spi_flash_responder;

    localparam int TB_BUSY = 300;   // long enough to issue a full opcode while busy
    localparam int HALF    = 80;    // SCK half period = 8 clk periods

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       SCK = 1'b0;
    logic       CSbar = 1'b1;
    logic       DI = 1'b0;
    logic       DO, busy, wel;
    logic [7:0] last_cmd;

    int checks = 0;
    int errors = 0;

    spi_flash_responder #(.MEM_AW(8), .BUSY_CYCLES(TB_BUSY)) dut (
        .clk(clk), .rst(rst), .SCK(SCK), .CSbar(CSbar), .DI(DI),
        .DO(DO), .busy(busy), .wel(wel), .last_cmd(last_cmd)
    );

    always #5 clk = ~clk;

    // Length of the most recent completed busy pulse, in clk cycles.
    int busy_run = 0;
    int busy_len = 0;
    always @(negedge clk) begin
        busy_run <= busy ? busy_run + 1 : 0;
        if (!busy && busy_run > 0) busy_len <= busy_run;
    end

    // Byte-level flash model.
    logic [7:0] m_mem [256];
    logic       m_wel = 1'b0;
    logic       m_busy = 1'b0;
    logic [7:0] m_last = 8'h00;
    logic [7:0] tx_q[$], rx_q[$], ex_q[$];

    task automatic model_txn();
        logic [7:0] op, p;
        bit wrote;
        ex_q.delete();
        for (int i = 0; i < tx_q.size(); i++) ex_q.push_back(8'h00);
        op = tx_q[0];
        m_last = op;
        wrote = 0;
        if (m_busy && op != 8'h05) return;
        case (op)
            8'h06: m_wel = 1'b1;
            8'h04: m_wel = 1'b0;
            8'h05: for (int i = 1; i < tx_q.size(); i++) ex_q[i] = {6'b0, m_wel, m_busy};
            8'h03: if (tx_q.size() >= 4) begin
                p = tx_q[3];
                for (int i = 4; i < tx_q.size(); i++) begin ex_q[i] = m_mem[p]; p = p + 8'd1; end
            end
            8'h02: if (tx_q.size() >= 4) begin
                p = tx_q[3];
                for (int i = 4; i < tx_q.size(); i++) begin
                    if (m_wel) begin m_mem[p] = tx_q[i]; wrote = 1; end
                    p = p + 8'd1;
                end
                if (wrote) begin m_wel = 1'b0; m_busy = 1'b1; end
            end
            default: ;
        endcase
    endtask

    // Shift nbits of tx_q out on DI; DO is sampled just before each rise.
    task automatic spi_bits(input int nbits, input bit keep_cs);
        logic [7:0] b, r;
        r = 8'h00;
        rx_q.delete();
        CSbar = 1'b0;
        #(HALF);
        for (int i = 0; i < nbits; i++) begin
            b = tx_q[i / 8];
            if (i % 8 == 0) r = 8'h00;
            DI = b[7 - (i % 8)];
            #(HALF);
            r = {r[6:0], DO};
            SCK = 1'b1;
            #(HALF);
            SCK = 1'b0;
            if (i % 8 == 7) rx_q.push_back(r);
        end
        if (!keep_cs) begin
            #(HALF);
            CSbar = 1'b1;
            DI = 1'b0;
            #(HALF);
        end
    endtask

    task automatic run_full();
        model_txn();
        spi_bits(8 * tx_q.size(), 1'b0);
    endtask

    task automatic wait_idle(output bit ok);
        for (int k = 0; k < TB_BUSY + 100 && busy !== 1'b0; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        ok = (busy === 1'b0);
        m_busy = 1'b0;
    endtask

    task automatic test_reset();
        #100;
        checks += 4;
        if (DO !== 1'b0)   begin errors++; $display("FAIL reset_do: got %b expected 0", DO); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (wel !== 1'b0)  begin errors++; $display("FAIL reset_wel: got %b expected 0", wel); end
        if (last_cmd !== 8'h00) begin errors++; $display("FAIL reset_last_cmd: got %h expected 00", last_cmd); end
        rst = 1'b1;
        #100;
        tx_q = '{8'h05, 8'h00};
        run_full();
        checks += 4;
        if (rx_q[1] !== 8'h00 || rx_q[1] !== ex_q[1])
            begin errors++; $display("FAIL reset_status: got %h expected 00", rx_q[1]); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_status_busy: got %b expected 0", busy); end
        if (wel !== 1'b0)  begin errors++; $display("FAIL reset_status_wel: got %b expected 0", wel); end
        if (last_cmd !== 8'h05) begin errors++; $display("FAIL reset_status_last: got %h expected 05", last_cmd); end
    endtask

    task automatic test_wren_status();
        tx_q = '{8'h06};
        run_full();
        tx_q = '{8'h05, 8'h00, 8'h00};
        run_full();
        checks += 3;
        if (rx_q[1] !== 8'h02 || rx_q[1] !== ex_q[1])
            begin errors++; $display("FAIL wren_status: got %h expected 02", rx_q[1]); end
        if (rx_q[2] !== ex_q[2]) begin errors++; $display("FAIL wren_status_rep: got %h expected %h", rx_q[2], ex_q[2]); end
        if (wel !== 1'b1) begin errors++; $display("FAIL wren_wel: got %b expected 1", wel); end
    endtask

    task automatic test_program_read();
        bit ok;
        tx_q = '{8'h06};
        run_full();
        tx_q = '{8'h02, 8'h00, 8'h00, 8'h10, 8'hA5, 8'h3C};
        run_full();
        checks += 2;
        if (busy !== 1'b1) begin errors++; $display("FAIL prog_busy_set: got %b expected 1", busy); end
        if (wel !== m_wel) begin errors++; $display("FAIL prog_wel_clear: got %b expected %b", wel, m_wel); end
        wait_idle(ok);
        checks += 2;
        if (!ok) begin errors++; $display("FAIL prog_busy_timeout: busy still %b expected 0", busy); end
        if (busy_len !== TB_BUSY) begin errors++; $display("FAIL prog_busy_len: got %0d expected %0d", busy_len, TB_BUSY); end
        tx_q = '{8'h03, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00};
        run_full();
        checks += 2;
        if (rx_q[4] !== 8'hA5 || rx_q[4] !== ex_q[4]) begin errors++; $display("FAIL read_a5: got %h expected a5", rx_q[4]); end
        if (rx_q[5] !== 8'h3C || rx_q[5] !== ex_q[5]) begin errors++; $display("FAIL read_3c: got %h expected 3c", rx_q[5]); end
    endtask

    task automatic test_no_wren();
        tx_q = '{8'h02, 8'h00, 8'h00, 8'h20, 8'h77};
        run_full();
        checks += 2;
        if (busy !== 1'b0) begin errors++; $display("FAIL nowren_busy: got %b expected 0", busy); end
        if (wel !== 1'b0)  begin errors++; $display("FAIL nowren_wel: got %b expected 0", wel); end
        tx_q = '{8'h03, 8'h00, 8'h00, 8'h20, 8'h00};
        run_full();
        checks++;
        if (rx_q[4] !== 8'hFF || rx_q[4] !== ex_q[4]) begin errors++; $display("FAIL nowren_read: got %h expected ff", rx_q[4]); end
    endtask

    task automatic test_wrap();
        bit ok;
        tx_q = '{8'h03, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00};
        run_full();
        for (int i = 4; i < 6; i++) begin
            checks++;
            if (rx_q[i] !== ex_q[i]) begin errors++; $display("FAIL wrap_read byte %0d: got %h expected %h", i, rx_q[i], ex_q[i]); end
        end
        tx_q = '{8'h06};
        run_full();
        tx_q = '{8'h02, 8'h00, 8'h00, 8'hFF, 8'h11, 8'h22};
        run_full();
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL wrap_busy_timeout: busy %b expected 0", busy); end
        tx_q = '{8'h03, 8'h00, 8'h00, 8'hFF, 8'h00};
        run_full();
        checks++;
        if (rx_q[4] !== 8'h11 || rx_q[4] !== ex_q[4]) begin errors++; $display("FAIL wrap_ff: got %h expected 11", rx_q[4]); end
        tx_q = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h00};
        run_full();
        checks++;
        if (rx_q[4] !== 8'h22 || rx_q[4] !== ex_q[4]) begin errors++; $display("FAIL wrap_00: got %h expected 22", rx_q[4]); end
    endtask

    task automatic test_busy_ignore();
        bit ok;
        tx_q = '{8'h06};
        run_full();
        tx_q = '{8'h02, 8'h00, 8'h00, 8'h40, 8'h5A};
        run_full();
        tx_q = '{8'h03, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00};
        run_full();
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (rx_q[i] !== 8'h00 || rx_q[i] !== ex_q[i]) begin errors++; $display("FAIL busy_read byte %0d: got %h expected 00", i, rx_q[i]); end
        end
        checks++;
        if (last_cmd !== 8'h03) begin errors++; $display("FAIL busy_last_cmd: got %h expected 03", last_cmd); end
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL busy_timeout: busy %b expected 0", busy); end
        // Status polled across the busy window: first byte busy, later byte idle.
        tx_q = '{8'h06};
        run_full();
        tx_q = '{8'h02, 8'h00, 8'h00, 8'h41, 8'hC7};
        run_full();
        tx_q = '{8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
        model_txn();
        spi_bits(40, 1'b0);
        checks += 2;
        if (rx_q[1] !== 8'h01) begin errors++; $display("FAIL poll_busy: got %h expected 01", rx_q[1]); end
        if (rx_q[4] !== 8'h00) begin errors++; $display("FAIL poll_done: got %h expected 00", rx_q[4]); end
        wait_idle(ok);
    endtask

    task automatic test_abort();
        tx_q = '{8'h03, 8'h00};
        m_last = 8'h03;
        spi_bits(13, 1'b0);
        checks++;
        if (last_cmd !== 8'h03) begin errors++; $display("FAIL abort_last: got %h expected 03", last_cmd); end
        tx_q = '{8'h05, 8'h00};
        run_full();
        checks += 2;
        if (rx_q[1] !== ex_q[1]) begin errors++; $display("FAIL abort_status: got %h expected %h", rx_q[1], ex_q[1]); end
        if (last_cmd !== 8'h05) begin errors++; $display("FAIL abort_status_last: got %h expected 05", last_cmd); end
    endtask

    task automatic test_reset_mid();
        tx_q = '{8'h06};
        run_full();
        tx_q = '{8'h02, 8'h00, 8'h00, 8'h50, 8'hC3};
        model_txn();
        spi_bits(40, 1'b1);
        #(HALF);
        rst = 1'b0;
        m_wel = 1'b0; m_busy = 1'b0; m_last = 8'h00;
        #100;
        checks += 3;
        if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        if (wel !== 1'b0)  begin errors++; $display("FAIL midrst_wel: got %b expected 0", wel); end
        if (last_cmd !== 8'h00) begin errors++; $display("FAIL midrst_last: got %h expected 00", last_cmd); end
        CSbar = 1'b1;
        DI = 1'b0;
        #(HALF);
        rst = 1'b1;
        #(HALF);
        tx_q = '{8'h03, 8'h00, 8'h00, 8'h50, 8'h00};
        run_full();
        checks++;
        if (rx_q[4] !== 8'hC3 || rx_q[4] !== ex_q[4]) begin errors++; $display("FAIL midrst_mem: got %h expected c3", rx_q[4]); end
    endtask

    task automatic test_random();
        logic [7:0] op;
        bit ok;
        for (int n = 0; n < 16; n++) begin
            case ($urandom_range(0, 5))
                0: op = 8'h06;
                1: op = 8'h04;
                2: op = 8'h05;
                3: op = 8'h03;
                4: op = 8'h02;
                default: begin
                    op = 8'($urandom_range(0, 255));
                    if (op inside {8'h02, 8'h03, 8'h04, 8'h05, 8'h06}) op = 8'hAB;
                end
            endcase
            tx_q.delete();
            tx_q.push_back(op);
            if (op == 8'h03 || op == 8'h02) begin
                tx_q.push_back(8'($urandom_range(0, 255)));
                tx_q.push_back(8'($urandom_range(0, 255)));
                tx_q.push_back(8'($urandom_range(8'h08, 8'h18)));
            end
            for (int d = $urandom_range(0, 3); d > 0; d--) tx_q.push_back(8'($urandom_range(0, 255)));
            run_full();
            for (int i = 0; i < ex_q.size(); i++) begin
                checks++;
                if (rx_q[i] !== ex_q[i]) begin errors++; $display("FAIL rand_%0d op %h byte %0d: got %h expected %h", n, op, i, rx_q[i], ex_q[i]); end
            end
            checks += 2;
            if (wel !== m_wel) begin errors++; $display("FAIL rand_%0d wel: got %b expected %b", n, wel, m_wel); end
            if (last_cmd !== m_last) begin errors++; $display("FAIL rand_%0d last_cmd: got %h expected %h", n, last_cmd, m_last); end
            if (m_busy) begin
                wait_idle(ok);
                checks++;
                if (!ok) begin errors++; $display("FAIL rand_%0d busy_timeout: busy %b expected 0", n, busy); end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) m_mem[i] = 8'hFF;
        test_reset();
        test_wren_status();
        test_program_read();
        test_no_wren();
        test_wrap();
        test_busy_ignore();
        test_abort();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
